// File: rtl/if_fetch_queue_pkg.sv
// if_pkg: exception codes and queue entry type shared by the fetch front end
package if_pkg;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_NONE = 5'd31;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        err;
        logic [4:0]  exc;
    } fetch_entry_t;
    localparam fetch_entry_t ENTRY_EMPTY = '{pc: 32'd0, pc4: 32'd0, instr: 32'd0, err: 1'b0, exc: EXC_NONE};
endpackage

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: redirect inputs, instruction-memory bus and ID-side queue head
interface if_fetch_queue_if;
    logic        exc_req, eret_req, br_req, im_req, out_valid, out_ready, out_err;
    logic [31:0] epc, br_target, im_addr, im_rdata, out_pc, out_pc4, out_instr;
    logic [4:0]  out_exc;
    modport master (
        input  exc_req, eret_req, epc, br_req, br_target, im_rdata, out_ready,
        output im_req, im_addr, out_valid, out_pc, out_pc4, out_instr, out_err, out_exc
    );
    modport slave (
        output exc_req, eret_req, epc, br_req, br_target, im_rdata, out_ready,
        input  im_req, im_addr, out_valid, out_pc, out_pc4, out_instr, out_err, out_exc
    );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush and registered head
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = (count != '0) ? mem[rd] : ENTRY_EMPTY;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC, 1-cycle instruction-memory driver and buffered fetch queue
module if_fetch_queue
    import if_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_4FFF,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          DEPTH      = 4
) (
    input logic               clk,
    input logic               reset,
    if_fetch_queue_if.master  bus
);
    logic [31:0] pc, issued_pc, target;
    logic inflight, halted, flush, bad_pc, issue, err_push, push, pop;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t din, head;
    always_comb begin
        flush    = bus.exc_req | bus.eret_req | bus.br_req;
        target   = bus.exc_req ? EXC_VECTOR : bus.eret_req ? bus.epc : bus.br_target;
        bad_pc   = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
        // inflight is counted as a reserved slot so the returning word always fits
        issue    = !reset && !halted && !flush && !bad_pc && (int'(count) + int'(inflight) < DEPTH);
        err_push = !reset && !halted && !flush && bad_pc && !inflight && (int'(count) < DEPTH);
        push     = !flush && (inflight || err_push);
        pop      = bus.out_valid && bus.out_ready;
        din      = inflight ? {issued_pc, issued_pc + 32'd4, bus.im_rdata, 1'b0, EXC_NONE}
                            : {pc, pc + 32'd4, 32'd0, 1'b1, EXC_ADEL};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_RESET;
            issued_pc <= PC_RESET;
            inflight  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            pc       <= flush ? target : issue ? pc + 32'd4 : pc;
            inflight <= issue;
            halted   <= !flush && (halted || err_push);
            if (issue) issued_pc <= pc;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (flush),
        .count (count),
        .head  (head)
    );
    assign bus.im_req    = issue;
    assign bus.im_addr   = pc;
    assign bus.out_valid = count != '0;
    assign bus.out_pc    = head.pc;
    assign bus.out_pc4   = head.pc4;
    assign bus.out_instr = head.instr;
    assign bus.out_err   = head.err;
    assign bus.out_exc   = head.exc;
endmodule
